// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants for the fetch stage and the datapath behind it.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Architectural address / PC width
  localparam int XLEN = 32;

  // Instruction word width
  localparam int INST_WIDTH = 32;

  // Default first fetch address after reset
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Sequential fetch increment (one 32-bit word)
  localparam int PC_STEP = 4;

  // addi x0, x0, 0 -- issued by the datapath while no instruction is valid
  localparam logic [INST_WIDTH-1:0] NOP = 32'h0000_0013;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous DEPTH-entry FIFO of {pc, instruction} pairs. Push and
//            pop may coincide at any occupancy including full; flush wins
//            over push.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [XLEN-1:0]       i_push_pc,
  input  logic [INST_WIDTH-1:0] i_push_inst,
  input  logic                  i_pop,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic [XLEN-1:0]       o_head_pc,
  output logic [INST_WIDTH-1:0] o_head_inst
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [XLEN-1:0]       r_pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_do_pop;
  logic w_do_push;

  // A pop from an empty FIFO is meaningless; a push into a full FIFO is only
  // accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != C_DEPTH) || w_do_pop);

  // Entry storage; cleared on reset so the head reads as zero afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_inst_mem[r_wr_ptr] <= i_push_inst;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage. Issues sequential word reads to instruction memory
//            under a credit limit, buffers in-order responses with their PCs
//            and hands them to the datapath. A redirect flushes buffered work
//            and turns in-flight requests into responses to be discarded.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  // instruction memory request channel
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  // instruction memory response channel (in order, latency >= 1)
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  // datapath channel
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [XLEN-1:0]       inst_pc,
  // control-flow redirect
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  // The stale counter can accumulate across back-to-back redirects, so it
  // carries two extra bits and new fetches pause while it is near the top.
  localparam int DW = CW + 2;

  localparam logic [CW:0]     C_DEPTH      = (CW + 1)'(DEPTH);
  localparam logic [DW-1:0]   C_DROP_LIMIT = DW'((2 ** DW) - 1 - DEPTH);
  localparam logic [XLEN-1:0] C_STEP       = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_fetch_pc_q;
  logic [XLEN-1:0] r_rsp_pc_q;
  logic [CW-1:0]   r_live_q;
  logic [DW-1:0]   r_drop_q;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_credit_ok;
  logic            w_drop_room;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_live;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_base;
  logic            w_unused_redirect_lsb;

  // Buffered plus in-flight instructions may never exceed the FIFO depth,
  // which is what keeps the FIFO from overflowing.
  assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_live_q}) < C_DEPTH;
  assign w_drop_room = (r_drop_q <= C_DROP_LIMIT);

  assign imem_req_valid = !reset && !redirect_valid && w_credit_ok && w_drop_room;
  assign imem_req_addr  = r_fetch_pc_q;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Stale responses are retired first; only then do responses count as live.
  // A response with nothing outstanding is ignored.
  assign w_rsp_drop = imem_rsp_valid && (r_drop_q != '0);
  assign w_rsp_live = imem_rsp_valid && (r_drop_q == '0) && (r_live_q != '0);

  assign w_pop = inst_valid && inst_ready;

  // Redirect targets are forced to word alignment; the low bits are don't-care
  assign w_redirect_base       = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch and response PCs track request issue and accepted responses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc_q <= RESET_PC;
      r_rsp_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc_q <= w_redirect_base;
      r_rsp_pc_q   <= w_redirect_base;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc_q <= r_fetch_pc_q + C_STEP;
      end
      if (w_rsp_live) begin
        r_rsp_pc_q <= r_rsp_pc_q + C_STEP;
      end
    end
  end

  // Outstanding-request accounting: live requests become stale on redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      r_live_q <= '0;
      r_drop_q <= '0;
    end else if (redirect_valid) begin
      r_live_q <= '0;
      r_drop_q <= r_drop_q + DW'(r_live_q) - DW'(w_rsp_drop || w_rsp_live);
    end else begin
      r_live_q <= r_live_q + CW'(w_req_fire) - CW'(w_rsp_live);
      if (w_rsp_drop) begin
        r_drop_q <= r_drop_q - DW'(1);
      end
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_rsp_live),
    .i_push_pc   (r_rsp_pc_q),
    .i_push_inst (imem_rsp_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_head_pc   (inst_pc),
    .o_head_inst (inst_data)
  );

  assign inst_valid = !w_empty;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch. A latency-programmable
//            in-order memory feeds the DUT; a stream-level reference model
//            (per-epoch PC sequence, credit count and expected FIFO contents)
//            predicts every observable output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;

  always #5 clock = ~clock;

  instruction_fetch #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  mreq_t memq[$];   // accepted requests awaiting response
  ent_t  mfifo[$];  // instructions the DUT should be presenting, in order

  int          epoch     = 0;
  logic [31:0] base      = '0;
  int          issued    = 0;
  int          popped    = 0;
  bit          known     = 0;
  int          cyc       = 0;
  int          last_due  = 0;
  int          lat       = 1;
  int          ready_pct = 100;
  int          iready_pct = 100;

  logic        s_req_valid, s_inst_valid, s_hs_req;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

  // One clock cycle: drive inputs, compare outputs with the model, advance it
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
    bit    exp_rv;
    bit    hs_rsp, hs_pop;
    int    d;
    mreq_t r;
    @(negedge clock);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < iready_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst_data  = inst_data;
    s_hs_req     = (s_req_valid === 1'b1) && imem_req_ready;

    exp_rv = !rst && !redir && known && ((issued - popped) < DEPTH);
    check_eq("req_valid", {63'd0, s_req_valid}, {63'd0, exp_rv});
    if (exp_rv && s_req_valid === 1'b1)
      check_eq("req_addr", {32'd0, s_req_addr}, {32'd0, base + 32'(4 * issued)});
    if (known) begin
      check_eq("inst_valid", {63'd0, s_inst_valid}, {63'd0, mfifo.size() > 0});
      if (mfifo.size() > 0 && s_inst_valid === 1'b1) begin
        check_eq("inst_pc", {32'd0, s_inst_pc}, {32'd0, mfifo[0].pc});
        check_eq("inst_data", {32'd0, s_inst_data}, {32'd0, mfifo[0].data});
      end
    end

    hs_rsp = imem_rsp_valid;
    hs_pop = (s_inst_valid === 1'b1) && inst_ready;
    if (hs_pop && mfifo.size() > 0) begin
      void'(mfifo.pop_front());
      popped++;
    end
    if (hs_rsp) begin
      r = memq.pop_front();
      if (known && !rst && !redir && r.epoch == epoch)
        mfifo.push_back('{pc: r.pc, data: r.data});
    end
    if (s_hs_req) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{pc: s_req_addr, data: mem_word(s_req_addr), due: d, epoch: epoch});
      issued++;
    end
    if (rst) begin
      epoch++;
      mfifo.delete();
      base   = RESET_PC;
      issued = 0;
      popped = 0;
      known  = 1;
    end else if (redir) begin
      epoch++;
      mfifo.delete();
      base   = {rpc[31:2], 2'b00};
      issued = 0;
      popped = 0;
    end
    cyc++;
  endtask

  // Let memory drain with no new requests, then reset for one cycle
  task automatic reset_clean();
    ready_pct = 0;
    for (int i = 0; i < 20 && memq.size() > 0; i++) step(0, 0, '0);
    step(1, 0, '0);
    ready_pct = 100;
  endtask

  task automatic run_until_req(input string tag, output logic [31:0] a);
    bit got;
    got = 0;
    a   = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0, '0);
      if (s_hs_req) begin
        got = 1;
        a   = s_req_addr;
      end
    end
    check_eq({tag, "_seen"}, {63'd0, got}, 64'd1);
  endtask

  task automatic run_until_inst(input string tag, output logic [31:0] pc, output logic [31:0] data);
    bit got;
    got  = 0;
    pc   = '0;
    data = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0, '0);
      if (s_inst_valid === 1'b1) begin
        got  = 1;
        pc   = s_inst_pc;
        data = s_inst_data;
      end
    end
    check_eq({tag, "_seen"}, {63'd0, got}, 64'd1);
  endtask

  initial begin
    logic [31:0] a, p, dd;

    // Reset and 1-cycle memory streaming
    lat = 1;
    step(1, 0, '0);
    step(1, 0, '0);
    check_eq("rst_req_valid", {63'd0, s_req_valid}, 64'd0);
    step(0, 0, '0);
    check_eq("rst_inst_valid", {63'd0, s_inst_valid}, 64'd0);
    check_eq("rst_inst_data", {32'd0, s_inst_data}, 64'd0);
    check_eq("rst_inst_pc", {32'd0, s_inst_pc}, 64'd0);
    check_eq("first_addr", {31'd0, s_req_valid, s_req_addr}, {31'd0, 1'b1, 32'h0});
    step(0, 0, '0);
    check_eq("second_addr", {32'd0, s_req_addr}, 64'h4);
    step(0, 0, '0);
    check_eq("third_addr", {32'd0, s_req_addr}, 64'h8);
    check_eq("first_inst_pc", {31'd0, s_inst_valid, s_inst_pc}, {31'd0, 1'b1, 32'h0});
    check_eq("first_inst_data", {32'd0, s_inst_data}, 64'h0050_0093);
    step(0, 0, '0);
    check_eq("second_inst", {s_inst_pc, s_inst_data}, {32'h4, 32'h00A0_0113});
    repeat (8) step(0, 0, '0);

    // Datapath stalled: credit limit caps the fetch at DEPTH requests
    reset_clean();
    iready_pct = 0;
    repeat (6) step(0, 0, '0);
    check_eq("stall_issued", 64'(issued), 64'(DEPTH));
    check_eq("stall_req_valid", {63'd0, s_req_valid}, 64'd0);
    check_eq("stall_inst_valid", {63'd0, s_inst_valid}, 64'd1);
    iready_pct = 100;
    run_until_req("resume", a);
    check_eq("resume_addr", {32'd0, a}, 64'h8);
    repeat (6) step(0, 0, '0);

    // Redirect with two requests in flight on a 3-cycle memory
    reset_clean();
    lat = 3;
    iready_pct = 0;
    step(0, 0, '0);
    step(0, 0, '0);
    check_eq("inflight", 64'(memq.size()), 64'd2);
    step(0, 1, 32'h0000_0100);
    iready_pct = 100;
    run_until_req("redir_req", a);
    check_eq("redir_addr", {32'd0, a}, 64'h100);
    run_until_inst("redir_inst", p, dd);
    check_eq("redir_inst_pc", {p, dd}, {32'h100, mem_word(32'h100)});
    repeat (6) step(0, 0, '0);

    // Misaligned redirect target
    lat = 1;
    step(0, 1, 32'h0000_0203);
    run_until_req("mis_req", a);
    check_eq("mis_addr", {32'd0, a}, 64'h200);
    run_until_inst("mis_inst", p, dd);
    check_eq("mis_inst_pc", {32'd0, p}, 64'h200);

    // Address wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC);
    run_until_req("wrap_req0", a);
    check_eq("wrap_addr0", {32'd0, a}, 64'hFFFF_FFFC);
    run_until_req("wrap_req1", a);
    check_eq("wrap_addr1", {32'd0, a}, 64'h0);
    repeat (6) step(0, 0, '0);

    // Reset mid-stream while responses are still arriving
    lat = 3;
    repeat (8) step(0, 0, '0);
    ready_pct = 0;
    step(1, 0, '0);
    for (int i = 0; i < 10 && memq.size() > 0; i++) begin
      step(0, 0, '0);
      check_eq("stray_inst_valid", {63'd0, s_inst_valid}, 64'd0);
    end
    ready_pct = 100;
    run_until_req("rst_restart", a);
    check_eq("rst_restart_addr", {32'd0, a}, 64'(RESET_PC));
    repeat (6) step(0, 0, '0);

    // Randomized traffic with redirects and varying memory latency
    ready_pct  = 75;
    iready_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(99) < 3) begin
        if ($urandom_range(3) == 0) step(0, 1, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
        else step(0, 1, $urandom);
      end else begin
        step(0, 0, '0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
